// File: rtl/actuator_sched.sv
// actuator_sched: three-channel PWM scheduler (heat, fan, light) with a shared
// 8-bit PWM counter, double-buffered duty registers and a heater/fan changeover
// FSM that inserts whole dead periods between the two mutually exclusive loads.
module actuator_sched #(
  parameter int unsigned PRESCALE     = 390,
  parameter int unsigned DEAD_PERIODS = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_ch,
  input  logic [7:0] cmd_duty,
  output logic       cmd_err,
  output logic       pid_HEAT,
  output logic       pid_FAN,
  output logic       pid_LIGHT,
  output logic       conflict,
  output logic [1:0] state_o
);

  localparam logic [15:0] PreMax   = 16'(PRESCALE - 1);
  localparam logic [3:0]  DeadLoad = 4'(DEAD_PERIODS);

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StHeat = 2'd1,
    StFan  = 2'd2,
    StDead = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    WinNone = 2'd0,
    WinHeat = 2'd1,
    WinFan  = 2'd2
  } win_e;

  logic [15:0] r_pre;
  logic [7:0]  r_cnt;
  logic        r_rdy;
  logic        r_err;
  logic        r_conf;
  logic [7:0]  r_pend_heat, r_pend_fan, r_pend_light;
  logic [7:0]  r_shd_heat, r_shd_fan, r_shd_light;
  logic        r_pid_heat, r_pid_fan, r_pid_light;
  state_e      r_state, w_state_nxt;
  logic [3:0]  r_dead, w_dead_nxt;
  logic        w_tick, w_pb, w_acc;
  win_e        w_win;
  state_e      w_win_state;

  assign w_tick    = (r_pre == PreMax);
  assign w_pb      = w_tick && (r_cnt == 8'hFF);
  // r_rdy is low for the first cycle after reset release.
  assign cmd_ready = resetn && r_rdy && !w_pb;
  assign w_acc     = cmd_valid && cmd_ready;

  assign cmd_err   = r_err;
  assign conflict  = r_conf;
  assign pid_HEAT  = r_pid_heat;
  assign pid_FAN   = r_pid_fan;
  assign pid_LIGHT = r_pid_light;
  assign state_o   = r_state;

  // Winner is taken from the pending duties because they become the shadows at pb.
  always_comb begin
    w_win = WinNone;
    if ((r_pend_fan != 8'd0) && (r_pend_fan >= r_pend_heat)) begin
      w_win = WinFan;
    end else if (r_pend_heat != 8'd0) begin
      w_win = WinHeat;
    end
    unique case (w_win)
      WinHeat: w_win_state = StHeat;
      WinFan:  w_win_state = StFan;
      default: w_win_state = StOff;
    endcase
  end

  // Prescaler, PWM counter, command capture, shadow copy and conflict flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pre        <= 16'd0;
      r_cnt        <= 8'd0;
      r_rdy        <= 1'b0;
      r_err        <= 1'b0;
      r_conf       <= 1'b0;
      r_pend_heat  <= 8'd0;
      r_pend_fan   <= 8'd0;
      r_pend_light <= 8'd0;
      r_shd_heat   <= 8'd0;
      r_shd_fan    <= 8'd0;
      r_shd_light  <= 8'd0;
    end else begin
      r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
      if (w_tick) r_cnt <= r_cnt + 8'd1;
      r_rdy <= 1'b1;
      r_err <= w_acc && (cmd_ch == 2'd3);
      if (w_acc) begin
        case (cmd_ch)
          2'd0:    r_pend_heat  <= cmd_duty;
          2'd1:    r_pend_fan   <= cmd_duty;
          2'd2:    r_pend_light <= cmd_duty;
          default: ;
        endcase
      end
      if (w_pb) begin
        r_shd_heat  <= r_pend_heat;
        r_shd_fan   <= r_pend_fan;
        r_shd_light <= r_pend_light;
        r_conf      <= (r_pend_heat != 8'd0) && (r_pend_fan != 8'd0);
      end
    end
  end

  // FSM state and dead-period counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= StOff;
      r_dead  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_dead  <= w_dead_nxt;
    end
  end

  // Changeover FSM: transitions only on the period boundary.
  always_comb begin
    w_state_nxt = r_state;
    w_dead_nxt  = r_dead;
    if (w_pb) begin
      unique case (r_state)
        StOff: w_state_nxt = w_win_state;
        StHeat: begin
          if (w_win == WinFan) begin
            w_state_nxt = StDead;
            w_dead_nxt  = DeadLoad;
          end else begin
            w_state_nxt = w_win_state;
          end
        end
        StFan: begin
          if (w_win == WinHeat) begin
            w_state_nxt = StDead;
            w_dead_nxt  = DeadLoad;
          end else begin
            w_state_nxt = w_win_state;
          end
        end
        StDead: begin
          if (r_dead <= 4'd1) begin
            w_dead_nxt  = 4'd0;
            w_state_nxt = w_win_state;
          end else begin
            w_dead_nxt = r_dead - 4'd1;
          end
        end
      endcase
    end
  end

  // Registered PWM compares; heat and fan are exclusive because state is.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pid_heat  <= 1'b0;
      r_pid_fan   <= 1'b0;
      r_pid_light <= 1'b0;
    end else begin
      r_pid_heat  <= (r_state == StHeat) && (r_cnt < r_shd_heat);
      r_pid_fan   <= (r_state == StFan) && (r_cnt < r_shd_fan);
      r_pid_light <= (r_cnt < r_shd_light);
    end
  end

endmodule

// File: tb/tb_actuator_sched.sv
// Bench for actuator_sched at PRESCALE=1: directed scenarios plus a random
// command stream compared cycle by cycle with a period-level reference model.
module tb_actuator_sched;

  localparam int Dead = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_ch = 2'd0;
  logic [7:0] cmd_duty = 8'd0;
  logic       cmd_ready, cmd_err, pid_HEAT, pid_FAN, pid_LIGHT, conflict;
  logic [1:0] state_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  actuator_sched #(.PRESCALE(1), .DEAD_PERIODS(Dead)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ch    (cmd_ch),
    .cmd_duty  (cmd_duty),
    .cmd_err   (cmd_err),
    .pid_HEAT  (pid_HEAT),
    .pid_FAN   (pid_FAN),
    .pid_LIGHT (pid_LIGHT),
    .conflict  (conflict),
    .state_o   (state_o)
  );

  wire [7:0] w_dut_vec = {cmd_ready, cmd_err, pid_HEAT, pid_FAN, pid_LIGHT, conflict, state_o};

  // Reference model: phase within the 256-tick period, duties, mode (0 off,1 heat,2 fan,3 dead)
  int m_p = 0;
  int m_pend[4] = '{0, 0, 0, 0};
  int m_shd[4]  = '{0, 0, 0, 0};
  int m_mode = 0;
  int m_dead = 0;
  bit m_rdy = 0, m_err = 0, m_conf = 0, m_h = 0, m_f = 0, m_l = 0;

  task automatic model_edge();
    int win;
    bit pb, rdy;
    if (!resetn) begin
      m_p = 0; m_mode = 0; m_dead = 0;
      m_rdy = 0; m_err = 0; m_conf = 0; m_h = 0; m_f = 0; m_l = 0;
      for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_shd[i] = 0; end
      return;
    end
    pb  = (m_p == 255);
    rdy = m_rdy && !pb;
    m_h = (m_mode == 1) && (m_p < m_shd[0]);
    m_f = (m_mode == 2) && (m_p < m_shd[1]);
    m_l = (m_p < m_shd[2]);
    m_err = cmd_valid && rdy && (cmd_ch == 2'd3);
    if (cmd_valid && rdy && cmd_ch != 2'd3) m_pend[cmd_ch] = int'(cmd_duty);
    if (pb) begin
      for (int i = 0; i < 3; i++) m_shd[i] = m_pend[i];
      m_conf = (m_pend[0] != 0) && (m_pend[1] != 0);
      if (m_pend[0] == 0 && m_pend[1] == 0) win = 0;
      else if (m_pend[1] >= m_pend[0]) win = 2;
      else win = 1;
      case (m_mode)
        1: if (win == 2) begin m_mode = 3; m_dead = Dead; end else m_mode = win;
        2: if (win == 1) begin m_mode = 3; m_dead = Dead; end else m_mode = win;
        3: begin m_dead = m_dead - 1; if (m_dead == 0) m_mode = win; end
        default: m_mode = win;
      endcase
    end
    m_p = (m_p + 1) % 256;
    m_rdy = 1;
  endtask

  always @(posedge clk) model_edge();

  function automatic logic [7:0] model_vec();
    return {resetn && m_rdy && (m_p != 255), m_err, m_h, m_f, m_l, m_conf, 2'(m_mode)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_ch = ch; cmd_duty = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_pb();
    while (m_p != 255) @(negedge clk);
  endtask

  task automatic count_period(input int n, output int nh, output int nf, output int nl,
                              output int nd);
    nh = 0; nf = 0; nl = 0; nd = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      nh += int'(pid_HEAT);
      nf += int'(pid_FAN);
      nl += int'(pid_LIGHT);
      nd += int'(state_o == 2'd3);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if (w_dut_vec !== 8'h00) begin
      $display("FAIL reset_outputs got=%h exp=00", w_dut_vec); n_fail++;
    end
    resetn = 1'b1;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b0) begin
      $display("FAIL ready_before_edge got=%b exp=0", cmd_ready); n_fail++;
    end
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL ready_after_release got=%b exp=1", cmd_ready); n_fail++;
    end
    n_chk++;
    if (w_dut_vec !== model_vec()) begin
      $display("FAIL reset_model got=%h exp=%h", w_dut_vec, model_vec()); n_fail++;
    end
  endtask

  task automatic test_light();
    int nh, nf, nl, nd;
    do_reset();
    @(negedge clk);
    send(2'd2, 8'd64);
    wait_pb();
    @(negedge clk);
    count_period(256, nh, nf, nl, nd);
    n_chk++;
    if (nl != 64) begin $display("FAIL light64_p1 got=%0d exp=64", nl); n_fail++; end
    count_period(256, nh, nf, nl, nd);
    n_chk++;
    if (nl != 64) begin $display("FAIL light64_p2 got=%0d exp=64", nl); n_fail++; end
    n_chk++;
    if (nh + nf != 0) begin $display("FAIL light_only_hf got=%0d exp=0", nh + nf); n_fail++; end
  endtask

  task automatic test_changeover();
    int nh, nf, nl, nd;
    do_reset();
    @(negedge clk);
    send(2'd0, 8'd100);
    wait_pb();
    @(negedge clk);
    n_chk++;
    if (state_o !== 2'd1) begin $display("FAIL enter_heat got=%0d exp=1", state_o); n_fail++; end
    count_period(256, nh, nf, nl, nd);
    n_chk++;
    if (nh != 100) begin $display("FAIL heat100 got=%0d exp=100", nh); n_fail++; end
    send(2'd1, 8'd200);
    wait_pb();
    @(negedge clk);
    n_chk++;
    if ({conflict, state_o} !== 3'b1_11) begin
      $display("FAIL conflict_dead got=%b exp=111", {conflict, state_o}); n_fail++;
    end
    count_period(512, nh, nf, nl, nd);
    n_chk++;
    if (nh + nf != 0) begin $display("FAIL dead_outputs got=%0d exp=0", nh + nf); n_fail++; end
    n_chk++;
    if (nd != 511) begin $display("FAIL dead_length got=%0d exp=511", nd); n_fail++; end
    n_chk++;
    if (state_o !== 2'd2) begin $display("FAIL enter_fan got=%0d exp=2", state_o); n_fail++; end
    count_period(256, nh, nf, nl, nd);
    n_chk++;
    if (nf != 200 || nh != 0) begin
      $display("FAIL fan200 got fan=%0d heat=%0d exp 200/0", nf, nh); n_fail++;
    end
  endtask

  task automatic test_tie();
    int nh, nf, nl, nd;
    do_reset();
    @(negedge clk);
    send(2'd0, 8'd50);
    send(2'd1, 8'd50);
    wait_pb();
    @(negedge clk);
    n_chk++;
    if (state_o !== 2'd2) begin $display("FAIL tie_state got=%0d exp=2", state_o); n_fail++; end
    count_period(256, nh, nf, nl, nd);
    n_chk++;
    if (nf != 50 || nh != 0) begin
      $display("FAIL tie_duty got fan=%0d heat=%0d exp 50/0", nf, nh); n_fail++;
    end
  endtask

  task automatic test_pb_handshake();
    int nh, nf, nl, nd;
    do_reset();
    @(negedge clk);
    send(2'd2, 8'd32);
    n_chk++;
    if (cmd_err !== 1'b0) begin $display("FAIL err_valid_ch got=%b exp=0", cmd_err); n_fail++; end
    wait_pb();
    cmd_valid = 1'b1; cmd_ch = 2'd2; cmd_duty = 8'd96;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b0) begin $display("FAIL ready_at_pb got=%b exp=0", cmd_ready); n_fail++; end
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b1) begin $display("FAIL ready_after_pb got=%b exp=1", cmd_ready); n_fail++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_pb();
    @(negedge clk);
    count_period(256, nh, nf, nl, nd);
    n_chk++;
    if (nl != 96) begin $display("FAIL late_accept got=%0d exp=96", nl); n_fail++; end
    send(2'd3, 8'd200);
    n_chk++;
    if (cmd_err !== 1'b1) begin $display("FAIL err_pulse got=%b exp=1", cmd_err); n_fail++; end
    @(negedge clk);
    n_chk++;
    if (cmd_err !== 1'b0) begin $display("FAIL err_single got=%b exp=0", cmd_err); n_fail++; end
    wait_pb();
    @(negedge clk);
    count_period(256, nh, nf, nl, nd);
    n_chk++;
    if (nl != 96 || nh != 0 || nf != 0 || state_o !== 2'd0) begin
      $display("FAIL err_no_change got l=%0d h=%0d f=%0d st=%0d exp 96/0/0/0", nl, nh, nf,
               state_o);
      n_fail++;
    end
  endtask

  task automatic test_reset_dead();
    int nh, nf, nl, nd, nfan_st;
    do_reset();
    @(negedge clk);
    send(2'd0, 8'd100);
    wait_pb();
    @(negedge clk);
    send(2'd1, 8'd200);
    wait_pb();
    @(negedge clk);
    wait_pb();
    @(negedge clk);
    n_chk++;
    if (state_o !== 2'd3) begin $display("FAIL in_dead got=%0d exp=3", state_o); n_fail++; end
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    n_chk++;
    if (w_dut_vec !== 8'h00) begin
      $display("FAIL reset_in_dead got=%h exp=00", w_dut_vec); n_fail++;
    end
    resetn = 1'b1;
    nfan_st = 0; nf = 0; nh = 0; nl = 0;
    for (int i = 0; i < 3 * 256 + 5; i++) begin
      @(negedge clk);
      nfan_st += int'(state_o != 2'd0);
      nf += int'(pid_FAN);
      nh += int'(pid_HEAT);
      nl += int'(pid_LIGHT);
    end
    n_chk++;
    if (nfan_st != 0) begin $display("FAIL no_fsm_entry got=%0d exp=0", nfan_st); n_fail++; end
    n_chk++;
    if (nf + nh + nl != 0) begin
      $display("FAIL no_out_after_reset got=%0d exp=0", nf + nh + nl); n_fail++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2560; i++) begin
      n_chk++;
      if (w_dut_vec !== model_vec()) begin
        $display("FAIL rand_model cyc=%0d got=%h exp=%h", i, w_dut_vec, model_vec());
        n_fail++;
      end
      n_chk++;
      if (pid_HEAT === 1'b1 && pid_FAN === 1'b1) begin
        $display("FAIL heat_fan_overlap cyc=%0d got=11 exp=not both", i); n_fail++;
      end
      if ($urandom_range(0, 39) == 0) begin
        cmd_valid = 1'b1;
        cmd_ch = 2'($urandom_range(0, 3));
        cmd_duty = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_light();
    test_changeover();
    test_tie();
    test_pb_handshake();
    test_reset_dead();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
